// File: rtl/crc_engine.sv
// Parametrised CRC accumulator: folds DATA_W-bit words into a CRC_W-bit register, BPC bits per clock.
// Latency: a word accepted at edge T is busy for N = DATA_W/BPC cycles; done pulses in cycle T+N+1.
// Backpressure: start_i is only taken while busy_o is low; requests during a word are dropped, not queued.
module crc_engine #(
    parameter int                CRC_W     = 8,
    parameter logic [CRC_W-1:0]  POLY      = 8'h07,
    parameter int                DATA_W    = 8,
    parameter int                BPC       = 1,
    parameter int                MSB_FIRST = 1,
    parameter logic [CRC_W-1:0]  XOR_OUT   = 8'h00
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [CRC_W-1:0]  init_val_i,
    input  logic              clear_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [CRC_W-1:0]  result_o
);

    localparam int N     = DATA_W / BPC;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state;
    logic [CRC_W-1:0]   crc_reg;
    logic [CRC_W-1:0]   crc_next;
    logic [DATA_W-1:0]  sreg;
    logic [DATA_W-1:0]  sreg_next;
    logic [CNT_W-1:0]   cnt;
    logic               busy_q;
    logic               done_q;
    logic               bit_d;
    logic               fb;

    // Consume the next BPC stream bits: the word register shifts toward its consumed end so the
    // current bit always sits at a fixed position, and each bit is folded into the CRC in turn.
    always_comb begin
        crc_next  = crc_reg;
        sreg_next = sreg;
        bit_d     = 1'b0;
        fb        = 1'b0;
        for (int i = 0; i < BPC; i++) begin
            if (MSB_FIRST != 0) begin
                bit_d     = sreg_next[DATA_W-1];
                sreg_next = sreg_next << 1;
            end else begin
                bit_d     = sreg_next[0];
                sreg_next = sreg_next >> 1;
            end
            fb       = bit_d ^ crc_next[CRC_W-1];
            crc_next = {crc_next[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
    end

    // Control FSM and datapath state: reset > clear > start; clear reseeds and aborts any word,
    // but a clear coinciding with start in IDLE still accepts the word against the fresh seed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            crc_reg <= init_val_i;
            sreg    <= '0;
            cnt     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (clear_i) begin
                crc_reg <= init_val_i;
                cnt     <= '0;
                if (state == IDLE && start_i) begin
                    sreg   <= data_i;
                    state  <= SHIFT;
                    busy_q <= 1'b1;
                end else begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (start_i) begin
                            sreg   <= data_i;
                            cnt    <= '0;
                            state  <= SHIFT;
                            busy_q <= 1'b1;
                        end
                    end
                    SHIFT: begin
                        crc_reg <= crc_next;
                        sreg    <= sreg_next;
                        cnt     <= cnt + CNT_W'(1);
                        if (cnt == LAST) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = crc_reg ^ XOR_OUT;

endmodule

// File: tb/tb_crc_engine.sv
// Bench for crc_engine: four instances with different BPC / bit order / output XOR, a word-level
// reference model that predicts busy/done/result every cycle, and literal known-answer checks.
// Inputs change 1 time unit after the rising edge; the per-cycle compare runs on the falling edge.
module tb_crc_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic [7:0] init;
    logic       start  [4];
    logic [7:0] data   [4];
    logic       busy   [4];
    logic       done   [4];
    logic [7:0] result [4];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Instance 0: defaults. 1: whole byte per clock. 2: LSB first, 2 bits/clk, inverted output. 3: LSB first.
    crc_engine #(.CRC_W(8), .POLY(8'h07), .DATA_W(8), .BPC(1), .MSB_FIRST(1), .XOR_OUT(8'h00)) u_d0 (
        .clk_i(clk), .rst_i(rst), .init_val_i(init), .clear_i(clear), .start_i(start[0]),
        .data_i(data[0]), .busy_o(busy[0]), .done_o(done[0]), .result_o(result[0]));
    crc_engine #(.CRC_W(8), .POLY(8'h07), .DATA_W(8), .BPC(8), .MSB_FIRST(1), .XOR_OUT(8'h00)) u_d1 (
        .clk_i(clk), .rst_i(rst), .init_val_i(init), .clear_i(clear), .start_i(start[1]),
        .data_i(data[1]), .busy_o(busy[1]), .done_o(done[1]), .result_o(result[1]));
    crc_engine #(.CRC_W(8), .POLY(8'h07), .DATA_W(8), .BPC(2), .MSB_FIRST(0), .XOR_OUT(8'hFF)) u_d2 (
        .clk_i(clk), .rst_i(rst), .init_val_i(init), .clear_i(clear), .start_i(start[2]),
        .data_i(data[2]), .busy_o(busy[2]), .done_o(done[2]), .result_o(result[2]));
    crc_engine #(.CRC_W(8), .POLY(8'h07), .DATA_W(8), .BPC(1), .MSB_FIRST(0), .XOR_OUT(8'h00)) u_d3 (
        .clk_i(clk), .rst_i(rst), .init_val_i(init), .clear_i(clear), .start_i(start[3]),
        .data_i(data[3]), .busy_o(busy[3]), .done_o(done[3]), .result_o(result[3]));

    function automatic int n_of(int i);
        case (i)
            1:       return 1;
            2:       return 4;
            default: return 8;
        endcase
    endfunction

    function automatic bit msb_of(int i);
        return (i < 2);
    endfunction

    function automatic logic [7:0] xo_of(int i);
        return (i == 2) ? 8'hFF : 8'h00;
    endfunction

    // Whole-word CRC update: stream the 8 bits in the chosen order through the polynomial division.
    function automatic logic [7:0] crc_word(logic [7:0] c, logic [7:0] d, bit msb);
        logic [7:0] r;
        logic       b;
        r = c;
        for (int k = 0; k < 8; k++) begin
            b = msb ? d[7-k] : d[k];
            if ((b ^ r[7]) == 1'b1) r = {r[6:0], 1'b0} ^ 8'h07;
            else                    r = {r[6:0], 1'b0};
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word-level model: the CRC of a word is computed when it is accepted and becomes visible
    // after the word's N busy cycles; clear/reset discard it.
    logic [7:0] mcrc  [4];
    logic [7:0] pend  [4];
    int         rem   [4];
    bit         mdone [4];
    bit         chk_en = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                mcrc[i]  = init;
                rem[i]   = 0;
                mdone[i] = 1'b0;
            end else begin
                mdone[i] = 1'b0;
                if (rem[i] > 0) begin
                    if (clear) begin
                        mcrc[i] = init;
                        rem[i]  = 0;
                    end else begin
                        rem[i] = rem[i] - 1;
                        if (rem[i] == 0) begin
                            mcrc[i]  = pend[i];
                            mdone[i] = 1'b1;
                        end
                    end
                end else begin
                    if (clear) mcrc[i] = init;
                    if (start[i] === 1'b1) begin
                        pend[i] = crc_word(mcrc[i], data[i], msb_of(i));
                        rem[i]  = n_of(i);
                    end
                end
            end
        end
        chk_en = 1'b1;
    end

    // Per-cycle compare; mid-word CRC values are not architecturally defined, so result is only
    // checked while the model says the instance is idle.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("busy%0d", i), busy[i], (rem[i] > 0));
                chk($sformatf("done%0d", i), done[i], mdone[i]);
                if (rem[i] == 0) chk($sformatf("result%0d", i), result[i], mcrc[i] ^ xo_of(i));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_seed(input logic [7:0] v);
        init  = v;
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic accept(input int i, input logic [7:0] d);
        start[i] = 1'b1;
        data[i]  = d;
        tick();
        start[i] = 1'b0;
        data[i]  = 8'($urandom);
    endtask

    // Called in the first cycle after acceptance; returns in the done cycle (or after a bound).
    task automatic wait_done(input int i, output int cyc, output int bcnt);
        cyc  = 1;
        bcnt = 0;
        while (done[i] !== 1'b1 && cyc < 60) begin
            if (busy[i] === 1'b1) bcnt++;
            tick();
            cyc++;
        end
        start[i] = 1'b0;
    endtask

    task automatic run_123456789(input int i);
        int cyc, bc;
        clear_seed(8'h00);
        for (int k = 0; k < 9; k++) begin
            accept(i, 8'(8'h31 + k));
            wait_done(i, cyc, bc);
            chk($sformatf("b2b_spacing%0d_w%0d", i, k), cyc, n_of(i) + 1);
            chk($sformatf("b2b_busy%0d_w%0d", i, k), bc, n_of(i));
        end
        chk($sformatf("b2b_result%0d", i), result[i], 8'hF4);
    endtask

    initial begin
        int cyc, bc;
        rst   = 1'b1;
        clear = 1'b0;
        init  = 8'h3C;
        for (int i = 0; i < 4; i++) begin
            start[i] = 1'b0;
            data[i]  = 8'h00;
        end
        repeat (3) tick();
        chk("reset_result0", result[0], 8'h3C);
        chk("reset_result2", result[2], 8'hC3);
        chk("reset_busy0", busy[0], 1'b0);
        chk("reset_done0", done[0], 1'b0);
        rst = 1'b0;

        // Single word "1" with default parameters.
        clear_seed(8'h00);
        accept(0, 8'h31);
        wait_done(0, cyc, bc);
        chk("single_latency", cyc, 9);
        chk("single_busy_cycles", bc, 8);
        chk("single_result", result[0], 8'h97);

        // Check string "123456789", bit-serial and byte-per-clock.
        run_123456789(0);
        run_123456789(1);

        // LSB-first order, plain and with inverted output.
        clear_seed(8'h00);
        accept(3, 8'h8C);
        wait_done(3, cyc, bc);
        chk("lsb_result", result[3], 8'h97);
        clear_seed(8'h00);
        accept(2, 8'h8C);
        wait_done(2, cyc, bc);
        chk("lsb_bpc2_latency", cyc, 5);
        chk("lsb_xor_result", result[2], 8'h68);

        // Abort in the 4th shift cycle; a start presented alongside the clear must be ignored.
        clear_seed(8'h00);
        accept(0, 8'h31);
        tick(); tick(); tick();
        init     = 8'hAA;
        clear    = 1'b1;
        start[0] = 1'b1;
        tick();
        clear    = 1'b0;
        start[0] = 1'b0;
        chk("abort_busy", busy[0], 1'b0);
        chk("abort_done", done[0], 1'b0);
        chk("abort_result", result[0], 8'hAA);
        repeat (10) begin
            tick();
            chk("abort_no_done", done[0], 1'b0);
        end

        // start held high through the whole word is not re-accepted while busy.
        clear_seed(8'h00);
        start[0] = 1'b1;
        data[0]  = 8'h31;
        tick();
        data[0] = 8'($urandom);
        wait_done(0, cyc, bc);
        chk("held_start_latency", cyc, 9);
        chk("held_start_result", result[0], 8'h97);
        tick();
        chk("held_start_idle", busy[0], 1'b0);

        // Reset in the middle of a word.
        accept(0, 8'h31);
        tick(); tick();
        init = 8'h5A;
        rst  = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_result", result[0], 8'h5A);
        chk("midrst_busy", busy[0], 1'b0);
        chk("midrst_done", done[0], 1'b0);
        chk("midrst_result_xor", result[2], 8'hA5);

        // clear together with start: the word runs from the fresh seed regardless of history.
        accept(0, 8'($urandom));
        wait_done(0, cyc, bc);
        init     = 8'h00;
        clear    = 1'b1;
        start[0] = 1'b1;
        data[0]  = 8'h31;
        tick();
        clear    = 1'b0;
        start[0] = 1'b0;
        wait_done(0, cyc, bc);
        chk("clear_start_latency", cyc, 9);
        chk("clear_start_result", result[0], 8'h97);

        // Random traffic on all instances, checked cycle by cycle against the model.
        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom_range(0, 199) == 0);
            clear = ($urandom_range(0, 39) == 0);
            init  = 8'($urandom);
            for (int i = 0; i < 4; i++) begin
                start[i] = ($urandom_range(0, 2) == 0);
                data[i]  = 8'($urandom);
            end
            tick();
        end
        rst   = 1'b0;
        clear = 1'b0;
        for (int i = 0; i < 4; i++) start[i] = 1'b0;
        repeat (12) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
